csla_pipe: RTL

//  Parametrised, pipelined carry-select adder/subtractor with valid/ready flow control.

---
 rtl/csla_if.sv | 12 +
 rtl/csla_pipe.sv | 111 +++++++++++
 2 files changed

// File: rtl/csla_if.sv
// csla_if: operand/result valid-ready bundle for csla_pipe
interface csla_if #(
    parameter int WIDTH = 32
);
    logic             in_valid, in_ready, cin, sub;
    logic             out_valid, out_ready, cout, ovf;
    logic [WIDTH-1:0] a, b, sum;
    modport master (output in_valid, a, b, cin, sub, out_ready,
                    input  in_ready, out_valid, sum, cout, ovf);
    modport slave  (input  in_valid, a, b, cin, sub, out_ready,
                    output in_ready, out_valid, sum, cout, ovf);
endinterface

// File: rtl/csla_pipe.sv
// csla_pipe: pipelined carry-select adder/subtractor with per-stage valid/ready flow control
module csla_pipe #(
    parameter int WIDTH       = 32,
    parameter int BLOCK       = 4,
    parameter int BLK_PER_STG = 2
) (
    input logic   clk,
    input logic   rst,
    csla_if.slave io
);
    localparam int NBLK = WIDTH / BLOCK;
    localparam int LAT  = (NBLK + BLK_PER_STG - 1) / BLK_PER_STG;

    if (WIDTH % BLOCK != 0 || BLK_PER_STG < 1 || BLK_PER_STG > NBLK) begin : g_bad_cfg
        $error("csla_pipe: WIDTH must be a multiple of BLOCK and BLK_PER_STG must be 1..NBLK");
    end

    logic [LAT:0]     rdy;
    logic [LAT-1:0]   v_q, v_d, c_q, c_d, cm_q, cm_d;
    logic [WIDTH-1:0] a_q [LAT];
    logic [WIDTH-1:0] a_d [LAT];
    logic [WIDTH-1:0] b_q [LAT];
    logic [WIDTH-1:0] b_d [LAT];
    logic [WIDTH-1:0] s_q [LAT];
    logic [WIDTH-1:0] s_d [LAT];
    logic [WIDTH-1:0] ua, ub, us;
    logic             uv, uc, ucm;
    logic [BLOCK:0]   r0, r1;

    // Ready ripples back from the consumer; each stage resolves its own groups from upstream and loads when ready
    always_comb begin
        rdy = '0;
        rdy[LAT] = io.out_ready;
        for (int k = LAT - 1; k >= 0; k--) rdy[k] = !v_q[k] || rdy[k+1];
        v_d  = v_q;
        c_d  = c_q;
        cm_d = cm_q;
        a_d  = a_q;
        b_d  = b_q;
        s_d  = s_q;
        ua   = '0;
        ub   = '0;
        us   = '0;
        uv   = 1'b0;
        uc   = 1'b0;
        ucm  = 1'b0;
        r0   = '0;
        r1   = '0;
        for (int k = 0; k < LAT; k++) begin
            if (k == 0) begin
                uv  = io.in_valid;
                ua  = io.a;
                ub  = io.sub ? ~io.b : io.b;
                us  = '0;
                uc  = io.sub | io.cin;
                ucm = 1'b0;
            end else begin
                uv  = v_q[k-1];
                ua  = a_q[k-1];
                ub  = b_q[k-1];
                us  = s_q[k-1];
                uc  = c_q[k-1];
                ucm = cm_q[k-1];
            end
            for (int g = 0; g < NBLK; g++) begin
                if (g / BLK_PER_STG == k) begin
                    r0 = {1'b0, ua[g*BLOCK +: BLOCK]} + {1'b0, ub[g*BLOCK +: BLOCK]};
                    r1 = r0 + (BLOCK+1)'(1);
                    if (g == 0) begin
                        r0 = r0 + {{BLOCK{1'b0}}, uc};
                        r1 = r0;
                    end
                    us[g*BLOCK +: BLOCK] = uc ? r1[BLOCK-1:0] : r0[BLOCK-1:0];
                    uc = uc ? r1[BLOCK] : r0[BLOCK];
                    if (g == NBLK - 1) ucm = us[WIDTH-1] ^ ua[WIDTH-1] ^ ub[WIDTH-1];
                end
            end
            v_d[k]  = rdy[k] ? uv  : v_q[k];
            c_d[k]  = rdy[k] ? uc  : c_q[k];
            cm_d[k] = rdy[k] ? ucm : cm_q[k];
            a_d[k]  = rdy[k] ? ua  : a_q[k];
            b_d[k]  = rdy[k] ? ub  : b_q[k];
            s_d[k]  = rdy[k] ? us  : s_q[k];
        end
    end

    // Stage registers; reset empties the pipe and clears all held data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q  <= '0;
            c_q  <= '0;
            cm_q <= '0;
            a_q  <= '{default: '0};
            b_q  <= '{default: '0};
            s_q  <= '{default: '0};
        end else begin
            v_q  <= v_d;
            c_q  <= c_d;
            cm_q <= cm_d;
            a_q  <= a_d;
            b_q  <= b_d;
            s_q  <= s_d;
        end
    end

    assign io.in_ready  = rdy[0];
    assign io.out_valid = v_q[LAT-1];
    assign io.sum       = s_q[LAT-1];
    assign io.cout      = c_q[LAT-1];
    assign io.ovf       = cm_q[LAT-1] ^ c_q[LAT-1];
endmodule
